// File: rtl/tbird_input_ctrl_if.sv
// Raw DE2 inputs plus the conditioned step/clear/request bundle for the tail-light stages.
interface tbird_input_ctrl_if;
  logic       key_step_n;
  logic       key_clear_n;
  logic       sw_enable;
  logic       sw_dir;
  logic       sw_auto;
  logic       sw_hazard;
  logic       step;
  logic       clear;
  logic       left_req;
  logic       right_req;
  logic [1:0] mode;
  logic [1:0] phase;

  // step and clear are single-cycle strobes with no back-pressure: a light stage
  // acts on the cycle a strobe is high and samples left_req/right_req in that cycle.
  modport master (
    output key_step_n, key_clear_n, sw_enable, sw_dir, sw_auto, sw_hazard,
    input  step, clear, left_req, right_req, mode, phase
  );

  modport slave (
    input  key_step_n, key_clear_n, sw_enable, sw_dir, sw_auto, sw_hazard,
    output step, clear, left_req, right_req, mode, phase
  );
endinterface

// File: rtl/tbird_input_ctrl.sv
// Tail-light front end: sync, debounce, step/clear strobes and left/right arbitration.
// Optional macro HAZARD_EN adds a hazard request that lights both sides for a full cycle.
module tbird_input_ctrl #(
  parameter int DEB_CYCLES  = 50000,
  parameter int TICK_CYCLES = 12500000,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  tbird_input_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'b00,
    MODE_LEFT   = 2'b01,
    MODE_RIGHT  = 2'b10,
    MODE_HAZARD = 2'b11
  } mode_e;

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int TW = $clog2(TICK_CYCLES);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_CYCLES - 1);

  // Synchroniser bit map: 0 step key, 1 clear key, 2 enable, 3 dir, 4 auto, 5 hazard.
`ifdef HAZARD_EN
  localparam int NIN = 6;
`else
  localparam int NIN = 5;
`endif
  localparam logic [NIN-1:0] SYNC_RST = NIN'(2'b11);

  logic [NIN-1:0] raw;
  logic [NIN-1:0] sync_q [SYNC_STAGES];
  logic [NIN-1:0] synced;

`ifdef HAZARD_EN
  assign raw = {bus.sw_hazard, bus.sw_auto, bus.sw_dir, bus.sw_enable,
                bus.key_clear_n, bus.key_step_n};
`else
  assign raw = {bus.sw_auto, bus.sw_dir, bus.sw_enable,
                bus.key_clear_n, bus.key_step_n};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
    end else begin
      sync_q[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  logic en_s, dir_s, auto_s, haz_s;
  assign en_s   = synced[2];
  assign dir_s  = synced[3];
  assign auto_s = synced[4];
`ifdef HAZARD_EN
  assign haz_s  = synced[5];
`else
  assign haz_s  = 1'b0;
`endif

  // Debounce for both keys; a press event is the cycle the accepted level flips 1->0.
  logic [1:0]         key_acc_q, key_acc_d;
  logic [1:0][DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [1:0]         press;

  always_comb begin
    key_acc_d = key_acc_q;
    deb_cnt_d = deb_cnt_q;
    press     = 2'b00;
    for (int k = 0; k < 2; k++) begin
      if (synced[k] == key_acc_q[k]) begin
        deb_cnt_d[k] = '0;
      end else if (deb_cnt_q[k] == DEB_MAX) begin
        key_acc_d[k] = synced[k];
        deb_cnt_d[k] = '0;
        press[k]     = key_acc_q[k];
      end else begin
        deb_cnt_d[k] = deb_cnt_q[k] + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_acc_q <= 2'b11;
      deb_cnt_q <= '0;
    end else begin
      key_acc_q <= key_acc_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  // Tick counter idles at 0 outside auto mode and for the first cycle after a mode
  // change, so toggling sw_auto can never produce a stray wrap.
  logic [TW-1:0] tick_q, tick_d;
  logic          auto_prev_q;
  logic          tick_wrap, clear_evt, step_evt;

  assign tick_wrap = auto_s & auto_prev_q & (tick_q == TICK_MAX);
  assign clear_evt = press[1];
  assign step_evt  = (auto_s ? tick_wrap : press[0]) & ~clear_evt;

  always_comb begin
    tick_d = tick_q + TW'(1);
    if (clear_evt || !auto_s || !auto_prev_q || (tick_q == TICK_MAX)) tick_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_q      <= '0;
      auto_prev_q <= 1'b0;
    end else begin
      tick_q      <= tick_d;
      auto_prev_q <= auto_s;
    end
  end

  // Phase/mode FSM: the direction is latched only when a cycle starts at phase 0.
  mode_e      mode_q, mode_d;
  logic [1:0] phase_q, phase_d;
  logic       idle_left, idle_right;
  mode_e      target;

  assign idle_left  = haz_s | (en_s & ~dir_s);
  assign idle_right = haz_s | (en_s & dir_s);
  assign target     = haz_s ? MODE_HAZARD : (dir_s ? MODE_RIGHT : MODE_LEFT);

  always_comb begin
    mode_d  = mode_q;
    phase_d = phase_q;
    if (clear_evt) begin
      mode_d  = MODE_IDLE;
      phase_d = 2'd0;
    end else if (step_evt) begin
      if (phase_q == 2'd0) begin
        if (idle_left || idle_right) begin
          phase_d = 2'd1;
          mode_d  = target;
        end
      end else begin
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd3) mode_d = MODE_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q  <= MODE_IDLE;
      phase_q <= 2'd0;
    end else begin
      mode_q  <= mode_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    bus.left_req  = idle_left;
    bus.right_req = idle_right;
    if (phase_q != 2'd0) begin
      bus.left_req  = (mode_q == MODE_LEFT)  || (mode_q == MODE_HAZARD);
      bus.right_req = (mode_q == MODE_RIGHT) || (mode_q == MODE_HAZARD);
    end
  end

  assign bus.step  = step_evt;
  assign bus.clear = clear_evt;
  assign bus.mode  = mode_q;
  assign bus.phase = phase_q;

endmodule

// File: tb/tb_tbird_input_ctrl.sv
// Directed bench for tbird_input_ctrl with DEB_CYCLES=4, TICK_CYCLES=8, SYNC_STAGES=2.
module tb_tbird_input_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  tbird_input_ctrl_if ifc();

  tbird_input_ctrl #(
    .DEB_CYCLES (4),
    .TICK_CYCLES(8),
    .SYNC_STAGES(2)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (ifc)
  );

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  int step_cnt = 0;
  int clear_cnt = 0;
  int last_step = -1;
  int last_clear = -1;
  bit right_seen = 1'b0;
  bit mode3_seen = 1'b0;
  int st_q[$];
  int base, s0, c0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance to just after the active edge and log strobes/flags.
  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
    if (ifc.step === 1'b1) begin
      step_cnt++;
      last_step = cyc_n;
      st_q.push_back(cyc_n);
    end
    if (ifc.clear === 1'b1) begin
      clear_cnt++;
      last_clear = cyc_n;
    end
    if (ifc.right_req === 1'b1) right_seen = 1'b1;
    if (ifc.mode === 2'b11) mode3_seen = 1'b1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Hold one key low for 'hold' cycles, then release and let the release settle.
  task automatic press(input bit use_clear, input int hold);
    if (use_clear) ifc.key_clear_n = 1'b0;
    else           ifc.key_step_n  = 1'b0;
    cycles(hold);
    ifc.key_clear_n = 1'b1;
    ifc.key_step_n  = 1'b1;
    cycles(8);
  endtask

  initial begin
    ifc.key_step_n  = 1'b1;
    ifc.key_clear_n = 1'b1;
    ifc.sw_enable   = 1'b0;
    ifc.sw_dir      = 1'b0;
    ifc.sw_auto     = 1'b0;
    ifc.sw_hazard   = 1'b0;

    // Power-on reset
    #1 reset_n = 1'b0;
    #2;
    check("rst_step",  ifc.step,  0);
    check("rst_clear", ifc.clear, 0);
    check("rst_mode",  ifc.mode,  0);
    check("rst_phase", ifc.phase, 0);
    check("rst_lreq",  ifc.left_req,  0);
    check("rst_rreq",  ifc.right_req, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    cycles(20);
    check("idle_no_step",  step_cnt,  0);
    check("idle_no_clear", clear_cnt, 0);

    // Debounce: 3-cycle glitch ignored, 10-cycle press gives one step 5 cycles later
    s0 = step_cnt;
    press(1'b0, 3);
    check("glitch_no_step", step_cnt - s0, 0);
    s0 = step_cnt;
    base = cyc_n;
    press(1'b0, 10);
    check("press_one_step", step_cnt - s0, 1);
    check("press_latency",  last_step - base, 5);
    check("press_no_req_phase", ifc.phase, 0);

    // Manual left cycle
    ifc.sw_enable = 1'b1;
    ifc.sw_dir    = 1'b0;
    cycles(3);
    right_seen = 1'b0;
    check("left_pre_lreq", ifc.left_req,  1);
    check("left_pre_rreq", ifc.right_req, 0);
    for (int i = 1; i <= 4; i++) begin
      press(1'b0, 10);
      check("left_phase", ifc.phase, i % 4);
      check("left_mode",  ifc.mode,  (i == 4) ? 0 : 1);
    end
    check("left_never_rreq", right_seen, 0);

    // Direction flip at phase 2 does not disturb the running cycle
    press(1'b0, 10);
    press(1'b0, 10);
    check("flip_phase2", ifc.phase, 2);
    ifc.sw_dir = 1'b1;
    cycles(3);
    check("flip_p2_lreq", ifc.left_req,  1);
    check("flip_p2_rreq", ifc.right_req, 0);
    press(1'b0, 10);
    check("flip_p3_lreq", ifc.left_req,  1);
    check("flip_p3_rreq", ifc.right_req, 0);
    press(1'b0, 10);
    check("flip_p0_phase", ifc.phase, 0);
    check("flip_p0_mode",  ifc.mode,  0);
    check("flip_p0_lreq",  ifc.left_req,  0);
    check("flip_p0_rreq",  ifc.right_req, 1);

    // Hazard request with the turn signal off
    ifc.sw_enable = 1'b0;
    ifc.sw_dir    = 1'b0;
    ifc.sw_hazard = 1'b1;
    cycles(3);
`ifdef HAZARD_EN
    check("haz_lreq", ifc.left_req,  1);
    check("haz_rreq", ifc.right_req, 1);
    press(1'b0, 10);
    check("haz_mode",  ifc.mode,  3);
    check("haz_phase", ifc.phase, 1);
    check("haz_both",  {ifc.left_req, ifc.right_req}, 2'b11);
    press(1'b0, 10);
    press(1'b0, 10);
    check("haz_mode_p3", ifc.mode, 3);
    press(1'b0, 10);
    check("haz_end_mode", ifc.mode, 0);
`else
    check("nohaz_lreq", ifc.left_req,  0);
    check("nohaz_rreq", ifc.right_req, 0);
    press(1'b0, 10);
    check("nohaz_mode",  ifc.mode,  0);
    check("nohaz_phase", ifc.phase, 0);
`endif
    ifc.sw_hazard = 1'b0;

    // Auto mode: steps every 8 cycles, running a right cycle
    ifc.sw_enable = 1'b1;
    ifc.sw_dir    = 1'b1;
    cycles(3);
    st_q.delete();
    base = cyc_n;
    ifc.sw_auto = 1'b1;
    cycles(40);
    check("auto_count", st_q.size(), 4);
    if (st_q.size() >= 4) begin
      check("auto_first", st_q[0] - base, 10);
      for (int i = 1; i < 4; i++) check("auto_spacing", st_q[i] - st_q[i-1], 8);
    end
    check("auto_phase_end", ifc.phase, 0);
    check("auto_mode_end",  ifc.mode,  0);

    // Clear press lands on a wrap cycle
    cycles(5);
    ifc.key_clear_n = 1'b0;
    cycles(4);
    c0 = clear_cnt;
    cyc();
    check("wrapclr_clear", ifc.clear, 1);
    check("wrapclr_step",  ifc.step,  0);
    check("wrapclr_phase_before", ifc.phase, 1);
    cyc();
    check("wrapclr_phase", ifc.phase, 0);
    check("wrapclr_mode",  ifc.mode,  0);
    cycles(6);
    check("wrapclr_gap_step", ifc.step, 0);
    cyc();
    check("wrapclr_next_step", ifc.step, 1);
    ifc.key_clear_n = 1'b1;
    cycles(10);
    check("wrapclr_once", clear_cnt - c0, 1);
    check("auto_phase_mid", ifc.phase, 2);
    check("auto_mode_mid",  ifc.mode,  2);

    // Leaving auto mode issues no step
    ifc.sw_auto = 1'b0;
    s0 = step_cnt;
    cycles(12);
    check("auto_off_no_step", step_cnt - s0, 0);
    check("auto_off_phase",   ifc.phase, 2);

    // Manual clear press
    c0 = clear_cnt;
    base = cyc_n;
    press(1'b1, 10);
    check("clr_count",   clear_cnt - c0, 1);
    check("clr_latency", last_clear - base, 5);
    check("clr_phase",   ifc.phase, 0);
    check("clr_mode",    ifc.mode,  0);

    // Reset mid-cycle with both keys pressed
    press(1'b0, 10);
    press(1'b0, 10);
    check("pre_rst_phase", ifc.phase, 2);
    ifc.key_step_n  = 1'b0;
    ifc.key_clear_n = 1'b0;
    cycles(3);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_step",  ifc.step,  0);
    check("midrst_clear", ifc.clear, 0);
    check("midrst_mode",  ifc.mode,  0);
    check("midrst_phase", ifc.phase, 0);
    check("midrst_reqs",  {ifc.left_req, ifc.right_req}, 2'b00);
    ifc.sw_enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_hold_phase", ifc.phase, 0);
    ifc.key_step_n  = 1'b1;
    ifc.key_clear_n = 1'b1;
    @(negedge clk) reset_n = 1'b1;
    s0 = step_cnt;
    c0 = clear_cnt;
    cycles(20);
    check("postrst_no_step",  step_cnt - s0, 0);
    check("postrst_no_clear", clear_cnt - c0, 0);
    check("postrst_phase",    ifc.phase, 0);

`ifndef HAZARD_EN
    check("never_mode3", mode3_seen, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
